// File: rtl/ddr2_read_return_if.sv
// Read-issue, capture-buffer and return-stream signals of the DDR2 read-return sequencer.
// The slave side is the sequencer; the master side is the issue path, capture buffer and return sink.
interface ddr2_read_return_if #(
    parameter int TAG_W = 4
);
    logic             rd_issue_valid;
    logic [TAG_W-1:0] rd_issue_tag;
    logic             rd_issue_ready;
    logic             listen;
    logic [2:0]       read_ptr;
    logic [15:0]      buf_dout;
    logic             rd_valid;
    logic             rd_ready;
    logic [15:0]      rd_data;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_last;
    logic             overrun;
    logic             busy;

    modport master (
        output rd_issue_valid, rd_issue_tag, buf_dout, rd_ready,
        input  rd_issue_ready, listen, read_ptr, rd_valid, rd_data, rd_tag, rd_last, overrun, busy
    );

    modport slave (
        input  rd_issue_valid, rd_issue_tag, buf_dout, rd_ready,
        output rd_issue_ready, listen, read_ptr, rd_valid, rd_data, rd_tag, rd_last, overrun, busy
    );
endinterface

// File: rtl/ddr2_read_return.sv
// DDR2 read-return sequencer: times the capture-buffer listen pulse after each read issue,
// then drains the 8 captured beats into a tagged valid/ready stream.
module ddr2_read_return #(
    parameter int READ_LAT = 5,
    parameter int TAG_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    ddr2_read_return_if.slave  bus
);
    typedef logic [TAG_W-1:0] tag_t;

    logic [2:0]          space_q, space_d;
    logic [READ_LAT-1:0] dly_vld_q, dly_vld_d;
    tag_t                dly_tag_q [READ_LAT];
    tag_t                dly_tag_d [READ_LAT];
    logic                cap_active_q, cap_active_d;
    logic [2:0]          cap_idx_q, cap_idx_d;
    tag_t                cap_tag_q, cap_tag_d;
    logic                drn_active_q, drn_active_d;
    logic [2:0]          drn_idx_q, drn_idx_d;
    tag_t                drn_tag_q, drn_tag_d;
    logic                overrun_q, overrun_d;

    logic       ready_s;
    logic       accept_s;
    logic       listen_s;
    logic       xfer_s;
    logic       cap_edge_s;
    logic [2:0] cap_slot_s;
    logic       handoff_s;
    logic       ovr_s;

    assign ready_s    = !reset && (space_q == 3'd0);
    assign accept_s   = bus.rd_issue_valid && ready_s;
    assign listen_s   = dly_vld_q[READ_LAT-1];
    assign xfer_s     = drn_active_q && bus.rd_ready;
    // The slot written at the coming edge: 0 on the listen cycle, then cap_idx+1.
    assign cap_edge_s = listen_s || cap_active_q;
    assign cap_slot_s = listen_s ? 3'd0 : (cap_idx_q + 3'd1);
    assign handoff_s  = cap_active_q && (cap_idx_q == 3'd6);
    assign ovr_s      = cap_edge_s && drn_active_q &&
                        ((drn_idx_q < cap_slot_s) || ((drn_idx_q == cap_slot_s) && !xfer_s));

    // Issue spacing counter and the issue-to-listen delay line.
    always_comb begin
        space_d = space_q;
        if (accept_s) begin
            space_d = 3'd7;
        end else if (space_q != 3'd0) begin
            space_d = space_q - 3'd1;
        end else begin
            space_d = space_q;
        end
        dly_vld_d    = '0;
        dly_vld_d[0] = accept_s;
        dly_tag_d[0] = bus.rd_issue_tag;
        for (int i = 1; i < READ_LAT; i++) begin
            dly_vld_d[i] = dly_vld_q[i-1];
            dly_tag_d[i] = dly_tag_q[i-1];
        end
    end

    // Capture tracking and drain state, including overrun flush and handoff.
    always_comb begin
        cap_active_d = cap_active_q;
        cap_idx_d    = cap_idx_q;
        cap_tag_d    = cap_tag_q;
        if (listen_s) begin
            cap_active_d = 1'b1;
            cap_idx_d    = 3'd0;
            cap_tag_d    = dly_tag_q[READ_LAT-1];
        end else if (cap_active_q) begin
            cap_idx_d = cap_idx_q + 3'd1;
            if (cap_idx_q == 3'd6) begin
                cap_active_d = 1'b0;
            end else begin
                cap_active_d = 1'b1;
            end
        end else begin
            cap_active_d = 1'b0;
        end

        drn_active_d = drn_active_q;
        drn_idx_d    = drn_idx_q;
        drn_tag_d    = drn_tag_q;
        if (xfer_s) begin
            drn_idx_d = drn_idx_q + 3'd1;
            if (drn_idx_q == 3'd7) begin
                drn_active_d = 1'b0;
            end else begin
                drn_active_d = drn_active_q;
            end
        end else begin
            drn_idx_d = drn_idx_q;
        end
        // A stale burst is discarded; a handoff on the same edge still loads the new one.
        if (ovr_s) begin
            drn_active_d = 1'b0;
        end else begin
            drn_active_d = drn_active_d;
        end
        if (handoff_s) begin
            drn_active_d = 1'b1;
            drn_idx_d    = 3'd0;
            drn_tag_d    = cap_tag_q;
        end else begin
            drn_tag_d = drn_tag_q;
        end
        overrun_d = ovr_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            space_q      <= 3'd0;
            dly_vld_q    <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dly_tag_q[i] <= '0;
            end
            cap_active_q <= 1'b0;
            cap_idx_q    <= 3'd0;
            cap_tag_q    <= '0;
            drn_active_q <= 1'b0;
            drn_idx_q    <= 3'd0;
            drn_tag_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            space_q      <= space_d;
            dly_vld_q    <= dly_vld_d;
            for (int i = 0; i < READ_LAT; i++) begin
                dly_tag_q[i] <= dly_tag_d[i];
            end
            cap_active_q <= cap_active_d;
            cap_idx_q    <= cap_idx_d;
            cap_tag_q    <= cap_tag_d;
            drn_active_q <= drn_active_d;
            drn_idx_q    <= drn_idx_d;
            drn_tag_q    <= drn_tag_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rd_issue_ready = ready_s;
    assign bus.listen         = listen_s;
    assign bus.read_ptr       = drn_active_q ? drn_idx_q : 3'd0;
    assign bus.rd_valid       = drn_active_q;
    assign bus.rd_data        = bus.buf_dout;
    assign bus.rd_tag         = drn_tag_q;
    assign bus.rd_last        = drn_active_q && (drn_idx_q == 3'd7);
    assign bus.overrun        = overrun_q;
    assign bus.busy           = (|dly_vld_q) || cap_active_q || drn_active_q;
endmodule

// File: doc/ddr2_read_return.md
# ddr2_read_return

Read-return sequencer for the DDR2 controller datapath. Schedules the capture-buffer `listen` pulse a fixed read latency after each accepted read issue. Once all 8 beats of a burst are captured, it drains them through `read_ptr` into a valid/ready return stream tagged with the issuing request's tag. It sits between the protocol engine's read-issue path and the return FIFO, wrapped around the 8-entry read-capture buffer (listen / readPtr / dout interface).

## Interface
- `READ_LAT`, 5: cycles from issue acceptance to `listen` assertion; legal range 1..31.
- `TAG_W`, 4: request tag width.

- `clk` in 1: controller clock.
- `reset` in 1: synchronous, active-high.
- `rd_issue_valid` in 1: read command issued to DRAM this cycle.
- `rd_issue_tag` in TAG_W: tag for that read.
- `rd_issue_ready` out 1: issue accepted when valid && ready.
- `listen` out 1: one-cycle arm pulse to the capture buffer.
- `read_ptr` out 3: capture-buffer slot select.
- `buf_dout` in 16: capture-buffer selected word (combinational from `read_ptr`).
- `rd_valid` out 1: return beat valid.
- `rd_ready` in 1: downstream accepts beat.
- `rd_data` out 16: equals `buf_dout`.
- `rd_tag` out TAG_W: tag of the draining burst.
- `rd_last` out 1: beat 7 of the burst.
- `overrun` out 1: one-cycle pulse; an undrained burst was overwritten.
- `busy` out 1: any issue in flight, capture active, or drain active.

## Operation
- **Issue spacing:** acceptance loads a spacing counter with 7. `rd_issue_ready` = !reset && counter==0. Consequence: at most one accept per 8 cycles.
- **Delay line:** READ_LAT stages of {valid, tag}, advancing every cycle. When the output stage is valid, `listen`=1 for that cycle (cycle L) and capture state loads: cap_active=1, cap_idx=0, cap_tag=tag.
- **Capture tracking:** the buffer writes slot j at the edge ending cycle L+j, j=0..7. cap_idx increments each cycle; cap_active clears after the slot-7 edge.
- **Handoff:** at the slot-7 edge, the drain loads drn_active=1, drn_idx=0, drn_tag=cap_tag. The first beat is valid in cycle L+8. The drain is guaranteed idle or completing at that edge; otherwise overrun has already cleared it.
- **Drain:**
  - `rd_valid`=drn_active; `read_ptr`=drn_active ? drn_idx : cap_idx-independent 0; `rd_tag`=drn_tag; `rd_last`=drn_active && drn_idx==7.
  - On transfer (valid && ready), drn_idx increments. A transfer with drn_idx==7 clears drn_active.
  - Data and tag are held stable while valid && !ready.
- **Overrun:** at a capture edge writing slot j, the condition is drn_active && (drn_idx<j || (drn_idx==j && no transfer this cycle)). When it holds:
  - drn_active clears and the old burst's remaining beats are discarded.
  - `overrun` pulses the following cycle.
  - `rd_valid` may drop without handshake; this is the only permitted case.
- **Simultaneous events:** issue accept, listen, transfer and handoff are independent and may all occur in one cycle.

## Timing
- **Reset values:** `listen` 0, `read_ptr` 0, `rd_valid` 0, `rd_last` 0, `rd_tag` 0, `overrun` 0, `busy` 0, `rd_issue_ready` 0.
  - Reset clears the delay line, spacing counter, capture and drain state.
  - Mid-operation reset drops all in-flight reads with no later `listen`.
  - `rd_issue_ready`=1 in the first cycle after reset deasserts.
- **Latency:** issue accepted at cycle T → `listen` in cycle T+READ_LAT → beats valid T+READ_LAT+8 .. +15 with `rd_ready` held high.
- **Back-to-back throughput:** with 8-cycle issue spacing and `rd_ready` high, the stream is gapless and overrun never fires. Slot k is read in the same cycle it is rewritten, before the edge.
- **Registered/combinational split:** all outputs are registered-state derived except `rd_issue_ready` (depends on `reset`) and `rd_data`.

## Test plan
- **Single read:** READ_LAT=5, tag 3 accepted at cycle 0, model drives 0xA000+k on beat k, `rd_ready`=1 → `listen` in cycle 5; `rd_valid` cycles 13..20 with data 0xA000..0xA007; `rd_last` only in cycle 20; `rd_tag`=3; `overrun` never.
- **Back-to-back:** tags 1,2 accepted at cycles 0 and 8 → 16 contiguous beats in cycles 13..28; `rd_tag` changes 1→2 at cycle 21; no overrun.
- **Spacing:** `rd_issue_valid` held high from cycle 0 → accepts at cycles 0, 8, 16; `rd_issue_ready` low in cycles 1..7 and 9..15.
- **Backpressure:** single burst, `rd_ready` low in cycles 15..17 (beat 2 showing) → beat 2 data held stable; all 8 beats delivered in order; `rd_last` at cycle 23.
- **Overrun:** tags 1,2 at cycles 0 and 8, `rd_ready` low from cycle 13 → `overrun` pulse in cycle 14; from cycle 21, `rd_valid` with tag 2, beat 0; burst 1 never completes.
- **Reset mid-drain:** `reset` in cycle 15 of the single-read case → all outputs at reset values in cycle 16; no further `listen`; `rd_issue_ready`=1 in cycle 16 once `reset` is low.
